// File: rtl/smi_fuzz_pkg.sv
// rtl/smi_fuzz_pkg.sv - shared types, mode encodings and PRNG step for the memory fuzz sequencer
package smi_fuzz_pkg;

   typedef enum logic [2:0] {
      RESET,
      IDLE,
      GEN,
      WR_START,
      WR_WAIT,
      RD_START,
      RD_WAIT,
      REPORT
   } state_t;

   localparam logic [1:0] MODE_WR_RD   = 2'd0;
   localparam logic [1:0] MODE_WR_ONLY = 2'd1;
   localparam logic [1:0] MODE_RD_ONLY = 2'd2;
   localparam logic [1:0] MODE_ALIAS   = 2'd3;

   function automatic logic [63:0] xorshift64_step(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

endpackage

// File: rtl/smi_fuzz_param_gen.sv
// rtl/smi_fuzz_param_gen.sv - xorshift64 PRNG and per-burst address/length/pattern generation
module smi_fuzz_param_gen
   import smi_fuzz_pkg::*;
#(
   parameter int          DataWidth      = 64,
   parameter int          MinBurstLength = 64,
   parameter int          MaxBurstLength = 8192,
   parameter logic [63:0] RandSeed       = 64'h373E7B7D27C69FA4
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 i_advance,
   input  logic [63:0]          i_addr_base,
   input  logic [31:0]          i_block_size,
   output logic [63:0]          o_addr,
   output logic [31:0]          o_len,
   output logic [DataWidth-1:0] o_data_init,
   output logic [DataWidth-1:0] o_data_incr
);

   localparam int          Reps     = DataWidth / 64;
   localparam logic [31:0] WordMask = ~(32'(DataWidth / 8) - 32'd1);

   logic [63:0]          r_prng;
   logic [63:0]          r_addr;
   logic [31:0]          r_len;
   logic [DataWidth-1:0] r_data_init;
   logic [DataWidth-1:0] r_data_incr;

   logic [63:0] w_next;
   logic [63:0] w_incr64;
   logic [31:0] w_len_raw;
   logic [31:0] w_len;
   logic [31:0] w_off_raw;
   logic [31:0] w_off;

   // Parameters are derived from the post-advance PRNG value so each GEN uses a fresh draw.
   always_comb begin
      w_next    = xorshift64_step(r_prng);
      w_incr64  = {w_next[31:0], w_next[63:32]} | 64'd1;
      w_len_raw = {16'd0, w_next[47:32]} & (32'(MaxBurstLength) - 32'd1) & WordMask;
      w_len     = (w_len_raw < 32'(MinBurstLength)) ? 32'(MinBurstLength) : w_len_raw;
      w_off_raw = w_next[31:0] & (i_block_size - 32'd1) & WordMask;
      w_off     = ((33'(w_off_raw) + 33'(w_len)) > 33'(i_block_size)) ? (i_block_size - w_len)
                                                                        : w_off_raw;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_prng      <= RandSeed;
         r_addr      <= 64'd0;
         r_len       <= 32'd0;
         r_data_init <= '0;
         r_data_incr <= '0;
      end else if (i_advance) begin
         r_prng      <= w_next;
         r_addr      <= i_addr_base + 64'(w_off);
         r_len       <= w_len;
         r_data_init <= {Reps{w_next}};
         r_data_incr <= {Reps{w_incr64}};
      end
   end

   assign o_addr      = r_addr;
   assign o_len       = r_len;
   assign o_data_init = r_data_init;
   assign o_data_incr = r_data_incr;

endmodule

// File: rtl/smi_mem_fuzz_sequencer.sv
// rtl/smi_mem_fuzz_sequencer.sv - randomized write/read burst test sequencer; SMI_FUZZ_CYCLE_COUNT_EN adds run cycle counter
module smi_mem_fuzz_sequencer
   import smi_fuzz_pkg::*;
#(
   parameter int          DataWidth      = 64,
   parameter int          MinBurstLength = 64,
   parameter int          MaxBurstLength = 8192,
   parameter logic [63:0] RandSeed       = 64'h373E7B7D27C69FA4
) (
   input  logic                 clk,
   input  logic                 srst,
   input  logic                 cfg_valid,
   output logic                 cfg_stop,
   input  logic [63:0]          cfg_addr_base,
   input  logic [31:0]          cfg_block_size,
   input  logic [31:0]          cfg_num_tests,
   input  logic [1:0]           cfg_mode,
   output logic                 wr_req_valid,
   input  logic                 wr_req_stop,
   output logic [63:0]          wr_req_addr,
   output logic [31:0]          wr_req_len,
   output logic [DataWidth-1:0] wr_req_data_init,
   output logic [DataWidth-1:0] wr_req_data_incr,
   input  logic                 wr_done_valid,
   input  logic                 wr_done_ok,
   output logic                 wr_done_stop,
   output logic                 rd_req_valid,
   input  logic                 rd_req_stop,
   output logic [63:0]          rd_req_addr,
   output logic [31:0]          rd_req_len,
   output logic [DataWidth-1:0] rd_req_data_init,
   output logic [DataWidth-1:0] rd_req_data_incr,
   input  logic                 rd_done_valid,
   input  logic                 rd_done_ok,
   output logic                 rd_done_stop,
   output logic                 status_valid,
   input  logic                 status_stop,
   output logic [31:0]          status_error_count,
   output logic [63:0]          status_first_err_addr,
   output logic [31:0]          status_cycle_count
);

   state_t      r_state;
   logic [63:0] r_addr_base;
   logic [31:0] r_block_size;
   logic [31:0] r_remaining;
   logic [1:0]  r_mode;
   logic [31:0] r_err_count;
   logic [63:0] r_first_err_addr;

   state_t               w_state_next;
   state_t               w_next_test;
   logic                 w_advance;
   logic                 w_fail;
   logic [63:0]          w_burst_addr;
   logic [31:0]          w_burst_len;
   logic [DataWidth-1:0] w_burst_init;
   logic [DataWidth-1:0] w_burst_incr;

   smi_fuzz_param_gen #(
      .DataWidth      (DataWidth),
      .MinBurstLength (MinBurstLength),
      .MaxBurstLength (MaxBurstLength),
      .RandSeed       (RandSeed)
   ) u_param_gen (
      .clk          (clk),
      .srst         (srst),
      .i_advance    (w_advance),
      .i_addr_base  (r_addr_base),
      .i_block_size (r_block_size),
      .o_addr       (w_burst_addr),
      .o_len        (w_burst_len),
      .o_data_init  (w_burst_init),
      .o_data_incr  (w_burst_incr)
   );

   assign w_next_test = (r_remaining != 32'd0) ? GEN : REPORT;
   assign w_fail      = ((r_state == WR_WAIT) && wr_done_valid && !wr_done_ok) ||
                        ((r_state == RD_WAIT) && rd_done_valid && !rd_done_ok);

   always_ff @(posedge clk) begin
      if (srst) r_state <= RESET;
      else      r_state <= w_state_next;
   end

   // Handshake outputs are pure state decodes, so no input reaches them combinationally.
   always_comb begin
      w_state_next = r_state;
      w_advance    = 1'b0;
      cfg_stop     = 1'b1;
      wr_req_valid = 1'b0;
      rd_req_valid = 1'b0;
      wr_done_stop = 1'b1;
      rd_done_stop = 1'b1;
      status_valid = 1'b0;
      case (r_state)
         RESET: w_state_next = IDLE;
         IDLE: begin
            cfg_stop = 1'b0;
            if (cfg_valid) w_state_next = (cfg_num_tests == 32'd0) ? REPORT : GEN;
         end
         GEN: begin
            w_advance    = 1'b1;
            w_state_next = (r_mode == MODE_RD_ONLY) ? RD_START : WR_START;
         end
         WR_START: begin
            wr_req_valid = 1'b1;
            if (!wr_req_stop) w_state_next = WR_WAIT;
         end
         WR_WAIT: begin
            wr_done_stop = 1'b0;
            if (wr_done_valid) begin
               if ((r_mode == MODE_WR_ONLY) || !wr_done_ok) w_state_next = w_next_test;
               else                                         w_state_next = RD_START;
            end
         end
         RD_START: begin
            rd_req_valid = 1'b1;
            if (!rd_req_stop) w_state_next = RD_WAIT;
         end
         RD_WAIT: begin
            rd_done_stop = 1'b0;
            if (rd_done_valid) w_state_next = w_next_test;
         end
         REPORT: begin
            status_valid = 1'b1;
            if (!status_stop) w_state_next = IDLE;
         end
         default: w_state_next = RESET;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_addr_base      <= 64'd0;
         r_block_size     <= 32'd0;
         r_remaining      <= 32'd0;
         r_mode           <= MODE_WR_RD;
         r_err_count      <= 32'd0;
         r_first_err_addr <= '1;
      end else begin
         if ((r_state == IDLE) && cfg_valid) begin
            r_addr_base      <= cfg_addr_base;
            r_block_size     <= cfg_block_size;
            r_remaining      <= cfg_num_tests;
            r_mode           <= (cfg_mode == MODE_ALIAS) ? MODE_WR_RD : cfg_mode;
            r_err_count      <= 32'd0;
            r_first_err_addr <= '1;
         end
         if (w_advance) r_remaining <= r_remaining - 32'd1;
         if (w_fail) begin
            if (r_err_count != '1)    r_err_count      <= r_err_count + 32'd1;
            if (r_err_count == 32'd0) r_first_err_addr <= w_burst_addr;
         end
      end
   end

`ifdef SMI_FUZZ_CYCLE_COUNT_EN
   logic [31:0] r_cycle_count;

   always_ff @(posedge clk) begin
      if (srst) begin
         r_cycle_count <= 32'd0;
      end else if ((r_state == IDLE) && (w_state_next != IDLE)) begin
         r_cycle_count <= 32'd0;
      end else if ((r_state inside {GEN, WR_START, WR_WAIT, RD_START, RD_WAIT}) &&
                   (r_cycle_count != '1)) begin
         r_cycle_count <= r_cycle_count + 32'd1;
      end
   end

   assign status_cycle_count = r_cycle_count;
`else
   assign status_cycle_count = 32'd0;
`endif

   assign wr_req_addr           = w_burst_addr;
   assign wr_req_len            = w_burst_len;
   assign wr_req_data_init      = w_burst_init;
   assign wr_req_data_incr      = w_burst_incr;
   assign rd_req_addr           = w_burst_addr;
   assign rd_req_len            = w_burst_len;
   assign rd_req_data_init      = w_burst_init;
   assign rd_req_data_incr      = w_burst_incr;
   assign status_error_count    = r_err_count;
   assign status_first_err_addr = r_first_err_addr;

endmodule

// File: tb/tb_smi_mem_fuzz_sequencer.sv
// tb/tb_smi_mem_fuzz_sequencer.sv - randomized self-checking bench for smi_mem_fuzz_sequencer
`timescale 1ns/1ps
module tb_smi_mem_fuzz_sequencer;

   localparam int          DW        = 256;
   localparam int          MINB      = 64;
   localparam int          MAXB      = 8192;
   localparam int          BPW       = DW / 8;
   localparam logic [63:0] SEED      = 64'h373E7B7D27C69FA4;
   localparam int          RUN_LIMIT = 30000;

   typedef logic [DW-1:0] w_t;
   typedef struct {
      bit          is_rd;
      logic [63:0] addr;
      logic [31:0] len;
      w_t          init;
      w_t          incr;
      bit          ok;
   } req_t;

   logic        clk = 1'b0;
   logic        srst;
   logic        cfg_valid;
   logic        cfg_stop;
   logic [63:0] cfg_addr_base;
   logic [31:0] cfg_block_size;
   logic [31:0] cfg_num_tests;
   logic [1:0]  cfg_mode;
   logic        wr_req_valid, wr_req_stop;
   logic [63:0] wr_req_addr;
   logic [31:0] wr_req_len;
   w_t          wr_req_data_init, wr_req_data_incr;
   logic        wr_done_valid, wr_done_ok, wr_done_stop;
   logic        rd_req_valid, rd_req_stop;
   logic [63:0] rd_req_addr;
   logic [31:0] rd_req_len;
   w_t          rd_req_data_init, rd_req_data_incr;
   logic        rd_done_valid, rd_done_ok, rd_done_stop;
   logic        status_valid, status_stop;
   logic [31:0] status_error_count;
   logic [63:0] status_first_err_addr;
   logic [31:0] status_cycle_count;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [63:0] m_x;
   req_t        exp_q[$];

   always #5 clk = ~clk;

   smi_mem_fuzz_sequencer #(
      .DataWidth(DW), .MinBurstLength(MINB), .MaxBurstLength(MAXB), .RandSeed(SEED)
   ) dut (
      .clk(clk), .srst(srst),
      .cfg_valid(cfg_valid), .cfg_stop(cfg_stop), .cfg_addr_base(cfg_addr_base),
      .cfg_block_size(cfg_block_size), .cfg_num_tests(cfg_num_tests), .cfg_mode(cfg_mode),
      .wr_req_valid(wr_req_valid), .wr_req_stop(wr_req_stop), .wr_req_addr(wr_req_addr),
      .wr_req_len(wr_req_len), .wr_req_data_init(wr_req_data_init), .wr_req_data_incr(wr_req_data_incr),
      .wr_done_valid(wr_done_valid), .wr_done_ok(wr_done_ok), .wr_done_stop(wr_done_stop),
      .rd_req_valid(rd_req_valid), .rd_req_stop(rd_req_stop), .rd_req_addr(rd_req_addr),
      .rd_req_len(rd_req_len), .rd_req_data_init(rd_req_data_init), .rd_req_data_incr(rd_req_data_incr),
      .rd_done_valid(rd_done_valid), .rd_done_ok(rd_done_ok), .rd_done_stop(rd_done_stop),
      .status_valid(status_valid), .status_stop(status_stop), .status_error_count(status_error_count),
      .status_first_err_addr(status_first_err_addr), .status_cycle_count(status_cycle_count)
   );

   task automatic check(input string tag, input w_t obs, input w_t exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference burst generator: the PRNG recurrence, then length/offset by plain modular arithmetic.
   task automatic model_next(input logic [63:0] base, input logic [31:0] block, output req_t r);
      longint unsigned len, off, blk;
      logic [63:0]     sw;
      m_x = m_x ^ (m_x << 13);
      m_x = m_x ^ (m_x >> 7);
      m_x = m_x ^ (m_x << 17);
      blk = 64'(block);
      len = 64'(m_x[47:32]) % 64'(MAXB);
      len = len - (len % 64'(BPW));
      if (len < 64'(MINB)) len = 64'(MINB);
      off = 64'(m_x[31:0]) % blk;
      off = off - (off % 64'(BPW));
      if (off + len > blk) off = blk - len;
      sw = {m_x[31:0], m_x[63:32]} | 64'd1;
      r.is_rd = 1'b0;
      r.addr  = base + off;
      r.len   = 32'(len);
      for (int k = 0; k < DW / 64; k++) begin
         r.init[k*64 +: 64] = m_x;
         r.incr[k*64 +: 64] = sw;
      end
      r.ok = 1'b1;
   endtask

   task automatic compare_req(input string tag, input req_t f, input bit is_rd, input logic [63:0] a,
                              input logic [31:0] l, input w_t di, input w_t dc,
                              input logic [63:0] base, input logic [31:0] block);
      check({tag, ":kind"}, w_t'(is_rd), w_t'(f.is_rd));
      check({tag, ":addr"}, w_t'(a), w_t'(f.addr));
      check({tag, ":len"}, w_t'(l), w_t'(f.len));
      check({tag, ":data_init"}, di, f.init);
      check({tag, ":data_incr"}, dc, f.incr);
      check({tag, ":len_align"}, w_t'(l % 32'(BPW)), w_t'(0));
      check({tag, ":len_min"}, w_t'(l >= 32'(MINB)), w_t'(1));
      check({tag, ":len_max"}, w_t'(l <= 32'(MAXB)), w_t'(1));
      check({tag, ":in_window"}, w_t'((a >= base) && (a + 64'(l) <= base + 64'(block))), w_t'(1));
   endtask

   // Called at the negedge just after a reset edge; then confirms IDLE one cycle later.
   task automatic check_reset_state(input string tag);
      check({tag, ":cfg_stop"}, w_t'(cfg_stop), w_t'(1));
      check({tag, ":wr_req_valid"}, w_t'(wr_req_valid), w_t'(0));
      check({tag, ":rd_req_valid"}, w_t'(rd_req_valid), w_t'(0));
      check({tag, ":wr_done_stop"}, w_t'(wr_done_stop), w_t'(1));
      check({tag, ":rd_done_stop"}, w_t'(rd_done_stop), w_t'(1));
      check({tag, ":status_valid"}, w_t'(status_valid), w_t'(0));
      check({tag, ":err_count"}, w_t'(status_error_count), w_t'(0));
      check({tag, ":first_err"}, w_t'(status_first_err_addr), w_t'({64{1'b1}}));
      check({tag, ":cycle_count"}, w_t'(status_cycle_count), w_t'(0));
      @(negedge clk);
      check({tag, ":idle_cfg_stop"}, w_t'(cfg_stop), w_t'(0));
   endtask

   task automatic run(input string name, input logic [63:0] base, input logic [31:0] block,
                      input int ntests, input logic [1:0] mode, input int wr_fail_idx,
                      input int rd_fail_pct, input int first_stall, input bit abort);
      req_t        r, f;
      logic [1:0]  eff;
      logic [31:0] exp_err;
      logic [63:0] exp_first;
      int          n_wr_exp, n_rd_exp, n_wr, n_rd, meas, guard, stall_left, wr_dly, rd_dly, hold;
      bit          wr_pend, rd_pend, wr_ok, rd_ok, done, wr_passed;

      exp_q.delete();
      eff       = (mode == 2'd3) ? 2'd0 : mode;
      exp_err   = 32'd0;
      exp_first = '1;
      n_wr_exp  = 0;
      n_rd_exp  = 0;
      for (int t = 0; t < ntests; t++) begin
         model_next(base, block, r);
         wr_passed = 1'b1;
         if (eff != 2'd2) begin
            r.is_rd   = 1'b0;
            r.ok      = (t != wr_fail_idx);
            wr_passed = r.ok;
            exp_q.push_back(r);
            n_wr_exp++;
            if (!r.ok) begin
               if (exp_err == 32'd0) exp_first = r.addr;
               exp_err++;
            end
         end
         if ((eff != 2'd1) && wr_passed) begin
            r.is_rd = 1'b1;
            r.ok    = ($urandom_range(99) >= rd_fail_pct);
            exp_q.push_back(r);
            n_rd_exp++;
            if (!r.ok) begin
               if (exp_err == 32'd0) exp_first = r.addr;
               exp_err++;
            end
         end
      end

      @(negedge clk);
      guard = 0;
      while ((cfg_stop !== 1'b0) && (guard < 20)) begin
         @(negedge clk);
         guard++;
      end
      check({name, ":cfg_ready"}, w_t'(cfg_stop), w_t'(0));
      cfg_addr_base  = base;
      cfg_block_size = block;
      cfg_num_tests  = 32'(ntests);
      cfg_mode       = mode;
      cfg_valid      = 1'b1;
      @(negedge clk);
      cfg_valid      = 1'b0;
      cfg_addr_base  = {$urandom, $urandom};
      cfg_block_size = $urandom;
      cfg_num_tests  = $urandom;
      cfg_mode       = 2'($urandom);

      n_wr = 0; n_rd = 0; meas = 0; guard = 0; done = 1'b0;
      wr_pend = 1'b0; rd_pend = 1'b0; wr_ok = 1'b0; rd_ok = 1'b0; wr_dly = 0; rd_dly = 0;
      stall_left = first_stall;
      while (!done) begin
         if (status_valid === 1'b1) begin
            if (ntests == 0) check({name, ":zero_latency"}, w_t'(meas), w_t'(0));
            check({name, ":err_count"}, w_t'(status_error_count), w_t'(exp_err));
            check({name, ":first_err"}, w_t'(status_first_err_addr), w_t'(exp_first));
            check({name, ":n_wr"}, w_t'(n_wr), w_t'(n_wr_exp));
            check({name, ":n_rd"}, w_t'(n_rd), w_t'(n_rd_exp));
            check({name, ":leftover"}, w_t'(exp_q.size()), w_t'(0));
`ifdef SMI_FUZZ_CYCLE_COUNT_EN
            check({name, ":cycle_count"}, w_t'(status_cycle_count), w_t'(meas));
`else
            check({name, ":cycle_count"}, w_t'(status_cycle_count), w_t'(0));
`endif
            hold = $urandom_range(2);
            for (int h = 0; h < hold; h++) begin
               @(negedge clk);
               check({name, ":status_hold"}, w_t'(status_valid), w_t'(1));
               check({name, ":status_hold_err"}, w_t'(status_error_count), w_t'(exp_err));
            end
            status_stop = 1'b0;
            @(negedge clk);
            status_stop = 1'b1;
            check({name, ":status_released"}, w_t'(status_valid), w_t'(0));
            done = 1'b1;
         end else if (guard >= RUN_LIMIT) begin
            check({name, ":timeout_status_valid"}, w_t'(status_valid), w_t'(1));
            done = 1'b1;
         end else begin
            meas++;
            guard++;
            wr_req_stop = 1'b1; wr_done_valid = 1'b0;
            rd_req_stop = 1'b1; rd_done_valid = 1'b0;
            if (wr_req_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check({name, ":wr_unexpected"}, w_t'(wr_req_valid), w_t'(0));
                  wr_req_stop = 1'b0;
               end else if (stall_left > 0) begin
                  stall_left--;
                  compare_req({name, ":wr_hold"}, exp_q[0], 1'b0, wr_req_addr, wr_req_len,
                              wr_req_data_init, wr_req_data_incr, base, block);
               end else begin
                  f = exp_q.pop_front();
                  compare_req({name, ":wr"}, f, 1'b0, wr_req_addr, wr_req_len,
                              wr_req_data_init, wr_req_data_incr, base, block);
                  wr_req_stop = 1'b0;
                  wr_pend = 1'b1; wr_ok = f.ok; wr_dly = $urandom_range(3);
                  stall_left = $urandom_range(2);
                  n_wr++;
               end
            end
            if (rd_req_valid === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check({name, ":rd_unexpected"}, w_t'(rd_req_valid), w_t'(0));
                  rd_req_stop = 1'b0;
               end else if (stall_left > 0) begin
                  stall_left--;
                  compare_req({name, ":rd_hold"}, exp_q[0], 1'b1, rd_req_addr, rd_req_len,
                              rd_req_data_init, rd_req_data_incr, base, block);
               end else begin
                  f = exp_q.pop_front();
                  compare_req({name, ":rd"}, f, 1'b1, rd_req_addr, rd_req_len,
                              rd_req_data_init, rd_req_data_incr, base, block);
                  rd_req_stop = 1'b0;
                  rd_pend = 1'b1; rd_ok = f.ok; rd_dly = $urandom_range(3);
                  stall_left = $urandom_range(2);
                  n_rd++;
               end
            end
            if (wr_pend) begin
               if (wr_dly > 0) wr_dly--;
               else if (wr_done_stop === 1'b0) begin
                  wr_done_valid = 1'b1; wr_done_ok = wr_ok; wr_pend = 1'b0;
               end
            end
            if (rd_pend) begin
               if (rd_dly > 0) rd_dly--;
               else if (rd_done_stop === 1'b0) begin
                  rd_done_valid = 1'b1; rd_done_ok = rd_ok; rd_pend = 1'b0;
               end
            end
            if (abort && (rd_done_stop === 1'b0)) begin
               rd_done_valid = 1'b0;
               srst = 1'b1;
               @(negedge clk);
               srst = 1'b0;
               check_reset_state({name, ":reset"});
               exp_q.delete();
               done = 1'b1;
            end else begin
               @(negedge clk);
            end
         end
      end
   endtask

   initial begin
      srst = 1'b1;
      cfg_valid = 1'b0; cfg_addr_base = '0; cfg_block_size = '0; cfg_num_tests = '0; cfg_mode = '0;
      wr_req_stop = 1'b1; wr_done_valid = 1'b0; wr_done_ok = 1'b0;
      rd_req_stop = 1'b1; rd_done_valid = 1'b0; rd_done_ok = 1'b0;
      status_stop = 1'b1;
      m_x = SEED;
      repeat (3) @(negedge clk);
      srst = 1'b0;
      check_reset_state("por");

      run("basic4",  64'h0,                   32'h0001_0000,    4, 2'd0, -1,  0,  0, 1'b0);
      run("wrfail",  64'h1000,                32'h0000_4000,    3, 2'd0,  1,  0,  0, 1'b0);
      run("wronly",  64'h8000_0000,           32'h0000_8000,    3, 2'd1, -1,  0,  0, 1'b0);
      run("rdonly",  64'h2_0000,              32'h0000_2000,    3, 2'd2, -1, 50,  0, 1'b0);
      run("mode3",   64'h40,                  32'h0000_2000,    2, 2'd3, -1,  0,  0, 1'b0);
      run("zero",    64'h0,                   32'h0000_2000,    0, 2'd0, -1,  0,  0, 1'b0);
      run("stall",   64'h100,                 32'h0000_4000,    2, 2'd1, -1,  0, 10, 1'b0);
      run("long",    64'h1234_5678_0000_0000, 32'h0000_2000, 1000, 2'd0,  7, 10,  0, 1'b0);
      run("abort",   64'h0,                   32'h0000_4000,    3, 2'd0, -1,  0,  0, 1'b1);
      m_x = SEED;
      run("replay",  64'h0,                   32'h0000_4000,    2, 2'd0, -1,  0,  0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
